// File: rtl/aes_pkg.sv
// Shared AES definitions: field constants, engine FSM states and
// constant-coefficient GF(2^8) multipliers.
package aes_pkg;

   localparam int           NB       = 4;
   localparam int           BYTE_W   = 8;
   localparam logic [7:0]   AES_POLY = 8'h1B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } fsm_state_e;

   // Multiply by x modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

   // Only the coefficients used by (Inv)MixColumns; anything else passes through.
   function automatic logic [7:0] gmul_const(input logic [7:0] b, input logic [3:0] coeff);
      logic [7:0] x2, x4, x8, res;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      case (coeff)
         4'h2:    res = x2;
         4'h3:    res = x2 ^ b;
         4'h9:    res = x8 ^ b;
         4'hB:    res = x8 ^ x2 ^ b;
         4'hD:    res = x8 ^ x4 ^ b;
         4'hE:    res = x8 ^ x4 ^ x2;
         default: res = b;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational transform of one 32-bit state column, forward or inverse
// selected by i_inv_mode.
module mix_column_unit
   import aes_pkg::*;
(
   input  logic [NB*BYTE_W-1:0] i_col,
   input  logic                 i_inv_mode,
   output logic [NB*BYTE_W-1:0] o_col
);

   logic [BYTE_W-1:0] w_a [NB];

   for (genvar r = 0; r < NB; r++) begin : g_row
      assign w_a[r] = i_col[BYTE_W*r +: BYTE_W];

      // Row r uses the row-0 coefficient vector rotated right by r.
      assign o_col[BYTE_W*r +: BYTE_W] = i_inv_mode
         ? (gmul_const(w_a[r], 4'hE)          ^ gmul_const(w_a[(r+1)%NB], 4'hB) ^
            gmul_const(w_a[(r+2)%NB], 4'hD)   ^ gmul_const(w_a[(r+3)%NB], 4'h9))
         : (gmul_const(w_a[r], 4'h2)          ^ gmul_const(w_a[(r+1)%NB], 4'h3) ^
            w_a[(r+2)%NB]                     ^ w_a[(r+3)%NB]);
   end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential (Inv)MixColumns engine: transforms COLS_PER_CYC columns of a
// captured 128-bit state per cycle, with valid/ready on both sides.
module mix_columns_seq
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYC = 1,
   parameter int OUT_REG      = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         inv_mode,
   input  logic [127:0] data_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out,
   output logic         busy
);

   localparam int         COL_W    = NB * BYTE_W;
   localparam logic [1:0] LAST_CNT = 2'(NB - COLS_PER_CYC);
   localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYC);

   if (COLS_PER_CYC != 1 && COLS_PER_CYC != 2 && COLS_PER_CYC != 4) begin : g_bad_cpc
      $error("mix_columns_seq: COLS_PER_CYC must be 1, 2 or 4");
   end

   fsm_state_e   r_fsm, w_fsm_nxt;
   logic [1:0]   r_cnt;
   logic         r_mode;
   logic [127:0] r_state;
   logic [127:0] w_merged;
   logic         w_last;
   logic         w_capture;

   logic [1:0]       w_col_idx [COLS_PER_CYC];
   logic [COL_W-1:0] w_col_in  [COLS_PER_CYC];
   logic [COL_W-1:0] w_col_out [COLS_PER_CYC];

   for (genvar k = 0; k < COLS_PER_CYC; k++) begin : g_col
      assign w_col_idx[k] = r_cnt + 2'(k);
      assign w_col_in[k]  = r_state[{w_col_idx[k], 5'd0} +: COL_W];

      mix_column_unit u_mix_column_unit (
         .i_col      (w_col_in[k]),
         .i_inv_mode (r_mode),
         .o_col      (w_col_out[k])
      );
   end

   // Working state with the current column group replaced by its transform.
   always_comb begin
      w_merged = r_state;
      for (int k = 0; k < COLS_PER_CYC; k++) begin
         w_merged[{w_col_idx[k], 5'd0} +: COL_W] = w_col_out[k];
      end
   end

   assign w_last = (r_fsm == ST_BUSY) && (r_cnt == LAST_CNT);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm <= ST_IDLE;
      end else begin
         r_fsm <= w_fsm_nxt;
      end
   end

   // NOTE: every output of this block is given a default first, so no path
   // through the case statement can leave a value held and infer a latch.
   always_comb begin
      w_fsm_nxt = r_fsm;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      w_capture = 1'b0;
      case (r_fsm)
         ST_IDLE: begin
            in_ready = rst_n;
            if (in_valid) begin
               w_capture = 1'b1;
               w_fsm_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (w_last) begin
               if (OUT_REG == 0) begin
                  out_valid = 1'b1;
                  w_fsm_nxt = out_ready ? ST_IDLE : ST_DONE;
               end else begin
                  w_fsm_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready & rst_n;
            if (out_ready) begin
               if (in_valid) begin
                  w_capture = 1'b1;
                  w_fsm_nxt = ST_BUSY;
               end else begin
                  w_fsm_nxt = ST_IDLE;
               end
            end
         end
         default: w_fsm_nxt = ST_IDLE;
      endcase
   end

   // NOTE: the datapath registers are reset too, so data_out reads 0 after
   // reset and an aborted transaction leaves nothing visible behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= '0;
         r_mode  <= 1'b0;
         r_cnt   <= 2'd0;
      end else if (w_capture) begin
         r_state <= data_in;
         r_mode  <= inv_mode;
         r_cnt   <= 2'd0;
      end else if (r_fsm == ST_BUSY) begin
         r_state <= w_merged;
         r_cnt   <= w_last ? 2'd0 : r_cnt + CNT_STEP;
      end
   end

   assign busy     = (r_fsm != ST_IDLE);
   assign data_out = (OUT_REG == 0 && w_last) ? w_merged : r_state;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench: four engine configurations checked against a
// matrix-product GF(2^8) model, with directed and randomized traffic.
module tb_mix_columns_seq;

   localparam int NI = 4;

   function automatic int cpc_of(input int i);
      case (i)
         0:       return 1;
         1:       return 2;
         2:       return 4;
         default: return 2;
      endcase
   endfunction

   function automatic int oreg_of(input int i);
      return (i == 3) ? 0 : 1;
   endfunction

   localparam logic [127:0] V1  = 128'hc6c6c6c6_01010101_5c220af2_455313db;
   localparam logic [127:0] V1F = 128'hc6c6c6c6_01010101_9d58dc9f_bca14d8e;
   localparam logic [127:0] V3  = {96'h0, 32'hd5d4d4d4};
   localparam logic [127:0] V3F = {96'h0, 32'hd6d7d5d5};

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid  [NI];
   logic         inv_mode  [NI];
   logic         out_ready [NI];
   logic         in_ready  [NI];
   logic         out_valid [NI];
   logic         busy      [NI];
   logic [127:0] data_in   [NI];
   logic [127:0] data_out  [NI];

   int n_vec  = 0;
   int n_err  = 0;
   int cyc    = 0;
   int n_done = 0;

   logic [127:0] exp_q [NI][$];
   int           acc_cyc  [NI];
   bit           lat_pend [NI];
   bit           stall    [NI];
   logic [127:0] held     [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mix_columns_seq #(
         .COLS_PER_CYC (cpc_of(g)),
         .OUT_REG      (oreg_of(g))
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .inv_mode  (inv_mode[g]),
         .data_in   (data_in[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .data_out  (data_out[g]),
         .busy      (busy[g])
      );
   end

   // Generic shift-and-add multiply with reduction by 0x11B.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11B << (i - 8));
      return p[7:0];
   endfunction

   // out[r] = sum_j M[r][j] * a[j], with M[r][j] = base[(j - r) mod 4].
   function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
      logic [7:0]   base [4];
      logic [7:0]   acc;
      logic [127:0] o;
      if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(base[(j - r + 4) % 4], s[32*c + 8*j +: 8]);
            o[32*c + 8*r +: 8] = acc;
         end
      end
      return o;
   endfunction

   task automatic check(input string name, input int inst, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s inst%0d got %h want %h (t=%0t)", name, inst, act, exp, $time);
      end
   endtask

   // Compare process: scoreboard, latency, backpressure stability, idle outputs.
   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < NI; i++) begin
         if (!rst_n) begin
            exp_q[i].delete();
            stall[i]    = 1'b0;
            lat_pend[i] = 1'b0;
         end else begin
            if (stall[i]) begin
               check("hold_valid", i, 128'(out_valid[i]), 128'd1);
               check("hold_data", i, data_out[i], held[i]);
            end
            if (out_valid[i]) begin
               if (exp_q[i].size() == 0) begin
                  check("spurious_valid", i, 128'(out_valid[i]), 128'd0);
               end else begin
                  check("data", i, data_out[i], exp_q[i][0]);
                  if (out_ready[i]) begin
                     void'(exp_q[i].pop_front());
                     n_done++;
                  end
               end
               if (lat_pend[i]) begin
                  check("latency", i, 128'(cyc - acc_cyc[i]), 128'(4 / cpc_of(i) + oreg_of(i)));
                  lat_pend[i] = 1'b0;
               end
            end
            stall[i] = out_valid[i] && !out_ready[i];
            held[i]  = data_out[i];
            if (!busy[i]) begin
               check("idle_ready", i, 128'(in_ready[i]), 128'd1);
               check("idle_valid", i, 128'(out_valid[i]), 128'd0);
            end
            if (in_valid[i] && in_ready[i]) begin
               exp_q[i].push_back(model(data_in[i], inv_mode[i]));
               acc_cyc[i]  = cyc;
               lat_pend[i] = 1'b1;
            end
         end
      end
   end

   // Called #1 after a rising edge; returns #1 after the accepting edge.
   task automatic send(input int i, input logic [127:0] d, input logic m);
      int n;
      n = 0;
      in_valid[i] = 1'b1;
      data_in[i]  = d;
      inv_mode[i] = m;
      @(negedge clk);
      while (!in_ready[i] && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready[i]) check("send_timeout", i, 128'(in_ready[i]), 128'd1);
      @(posedge clk);
      #1;
      in_valid[i] = 1'b0;
   endtask

   task automatic wait_valid(input int i);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid[i] && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("out_valid_seen", i, 128'(out_valid[i]), 128'd1);
   endtask

   initial begin
      int start;
      int nc;
      logic [127:0] x;

      for (int i = 0; i < NI; i++) begin
         in_valid[i]  = 1'b0;
         inv_mode[i]  = 1'b0;
         out_ready[i] = 1'b1;
         data_in[i]   = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         check("rst_in_ready", i, 128'(in_ready[i]), 128'd0);
         check("rst_out_valid", i, 128'(out_valid[i]), 128'd0);
         check("rst_busy", i, 128'(busy[i]), 128'd0);
         check("rst_data_out", i, data_out[i], 128'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NI; i++) check("post_rst_ready", i, 128'(in_ready[i]), 128'd1);
      @(posedge clk);
      #1;

      check("model_fwd", 0, model(V1, 1'b0), V1F);
      check("model_inv", 0, model(V1F, 1'b1), V1);
      check("model_col", 0, model(V3, 1'b0), V3F);

      send(0, V1, 1'b0);
      wait_valid(0);
      check("t1_forward", 0, data_out[0], V1F);
      @(posedge clk); #1;

      send(0, V1F, 1'b1);
      wait_valid(0);
      check("t2_inverse", 0, data_out[0], V1);
      @(posedge clk); #1;

      send(2, V3, 1'b0);
      wait_valid(2);
      check("t3_cpc4", 2, data_out[2], V3F);
      @(posedge clk); #1;

      out_ready[0] = 1'b0;
      send(0, V1, 1'b0);
      wait_valid(0);
      repeat (10) begin
         @(negedge clk);
         check("bp_valid", 0, 128'(out_valid[0]), 128'd1);
         check("bp_in_ready", 0, 128'(in_ready[0]), 128'd0);
         check("bp_data", 0, data_out[0], V1F);
      end
      @(posedge clk); #1;
      out_ready[0] = 1'b1;
      in_valid[0]  = 1'b1;
      data_in[0]   = V1F;
      inv_mode[0]  = 1'b1;
      @(negedge clk);
      check("b2b_in_ready", 0, 128'(in_ready[0]), 128'd1);
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      check("b2b_busy", 0, 128'(busy[0]), 128'd1);
      check("b2b_out_valid", 0, 128'(out_valid[0]), 128'd0);
      wait_valid(0);
      check("b2b_data", 0, data_out[0], V1);
      @(posedge clk); #1;

      send(0, V1, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 0, 128'(out_valid[0]), 128'd0);
      check("abort_busy", 0, 128'(busy[0]), 128'd0);
      check("abort_in_ready", 0, 128'(in_ready[0]), 128'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_idle", 0, 128'(busy[0]), 128'd0);
      @(posedge clk); #1;
      send(0, V1, 1'b0);
      wait_valid(0);
      check("post_abort_data", 0, data_out[0], V1F);
      @(posedge clk); #1;

      for (int k = 0; k < 20; k++) begin
         x = {$urandom(), $urandom(), $urandom(), $urandom()};
         check("model_roundtrip", k, model(model(x, 1'b1), 1'b0), x);
      end

      start = n_done;
      nc    = 0;
      while ((n_done - start) < 1000 && nc < 30000) begin
         @(posedge clk); #1;
         nc++;
         for (int i = 0; i < NI; i++) begin
            in_valid[i]  = ($urandom_range(0, 9) < 6);
            inv_mode[i]  = 1'($urandom_range(0, 1));
            data_in[i]   = {$urandom(), $urandom(), $urandom(), $urandom()};
            out_ready[i] = ($urandom_range(0, 9) < 6);
         end
      end
      check("random_count", 0, 128'((n_done - start) >= 1000), 128'd1);

      for (int i = 0; i < NI; i++) begin
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b1;
      end
      repeat (20) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) check("drain_empty", i, 128'(exp_q[i].size()), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
